// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and the future transmitter:
// parity codes, oversampling constants and the receive FSM encoding.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned OVERSAMPLE = 16;

    // Sample indices within a 16-tick bit; the bit value is the vote of 7, 8 and 9.
    localparam logic [3:0] S_SAMPLE0 = 4'd7;
    localparam logic [3:0] S_SAMPLE1 = 4'd8;
    localparam logic [3:0] S_SAMPLE2 = 4'd9;
    localparam logic [3:0] S_LAST    = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every DIV clocks, with a
// synchronous clear so the tick phase can be aligned to an external event.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, majority-vote bit sampling,
// configurable frame format and a one-entry valid/ready holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV =
        (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_bad_params
        $error("uart_rx_param: illegal parameter combination");
    end

    logic tick, tick_clr;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    rx_state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [3:0]           s_q, s_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 samp7_q, samp7_d;
    logic                 samp8_q, samp8_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 break_q, break_d;
    logic                 overrun_q, overrun_d;

    logic rx_s, fall, maj, tick_mid, tick_end, complete;
    logic new_frame_err, new_parity_err, new_break, par_calc;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall     = rx_prev_q & ~rx_s;
    assign maj      = majority3(samp7_q, samp8_q, rx_s);
    assign tick_mid = tick && (s_q == S_SAMPLE2);
    assign tick_end = tick && (s_q == S_LAST);
    assign par_calc = ^{shift_q, par_q};

    always_comb begin
        new_frame_err = ~maj;
        new_break     = ~maj && (shift_q == '0) && (PARITY == PAR_NONE || !par_q);
        if (PARITY == PAR_ODD) begin
            new_parity_err = ~par_calc;
        end else if (PARITY == PAR_EVEN) begin
            new_parity_err = par_calc;
        end else begin
            new_parity_err = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], rs232_rx};
        rx_prev_d    = rx_s;
        s_d          = s_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        samp7_d      = samp7_q;
        samp8_d      = samp8_q;
        par_d        = par_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        break_d      = break_q;
        overrun_d    = 1'b0;
        tick_clr     = 1'b0;
        complete     = 1'b0;

        if (tick && state_q != StIdle && state_q != StWaitIdle) begin
            s_d = s_q + 4'd1;
            if (s_q == S_SAMPLE0) samp7_d = rx_s;
            if (s_q == S_SAMPLE1) samp8_d = rx_s;
        end

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    tick_clr = 1'b1;
                    s_d      = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick_mid && maj) begin
                    state_d = StIdle;
                end else if (tick_end) begin
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick_mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (tick_end) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (tick_mid) par_d = maj;
                if (tick_end) state_d = StStop;
            end
            StStop: begin
                // Frame ends mid-stop-bit so a following start edge is never missed.
                if (tick_mid) begin
                    complete = 1'b1;
                    s_d      = '0;
                    state_d  = maj ? StIdle : StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = new_frame_err;
                parity_err_d = new_parity_err;
                break_d      = new_break;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            s_q          <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            samp7_q      <= 1'b1;
            samp8_q      <= 1'b1;
            par_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rx_prev_q    <= rx_prev_d;
            s_q          <= s_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            samp7_q      <= samp7_d;
            samp8_q      <= samp8_d;
            par_q        <= par_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance driven
// with hand-built frames at 432 clk per bit.
module tb_uart_rx_param;

    localparam int BIT = 432;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rx_n = 1'b1, ready_n = 1'b1;
    logic [7:0] data_n;
    logic       valid_n, ferr_n, perr_n, brk_n, ovr_n, busy_n;

    logic       rx_e = 1'b1, ready_e = 1'b1;
    logic [7:0] data_e;
    logic       valid_e, ferr_e, perr_e, brk_e, ovr_e, busy_e;

    uart_rx_param #(
        .CLK_FREQ(50_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_n (
        .clk(clk), .rst(rst), .rs232_rx(rx_n), .rx_data(data_n), .rx_valid(valid_n),
        .rx_ready(ready_n), .frame_err(ferr_n), .parity_err(perr_n), .break_det(brk_n),
        .overrun(ovr_n), .busy(busy_n)
    );

    uart_rx_param #(
        .CLK_FREQ(50_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_e (
        .clk(clk), .rst(rst), .rs232_rx(rx_e), .rx_data(data_e), .rx_valid(valid_e),
        .rx_ready(ready_e), .frame_err(ferr_e), .parity_err(perr_e), .break_det(brk_e),
        .overrun(ovr_e), .busy(busy_e)
    );

    // Entries are {break_det, parity_err, frame_err, rx_data}, logged on each handshake.
    logic [10:0] qn[$];
    logic [10:0] qe[$];
    int ovr_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_n && ready_n) qn.push_back({brk_n, perr_n, ferr_n, data_n});
            if (valid_e && ready_e) qe.push_back({brk_e, perr_e, ferr_e, data_e});
            if (ovr_n) ovr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [10:0] e, input logic [7:0] d,
                              input logic f, input logic p, input logic b);
        check({tag, ".data"}, 32'(e[7:0]), 32'(d));
        check({tag, ".frame_err"}, 32'(e[8]), 32'(f));
        check({tag, ".parity_err"}, 32'(e[9]), 32'(p));
        check({tag, ".break_det"}, 32'(e[10]), 32'(b));
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int sel, input logic v);
        if (sel == 0) rx_n = v;
        else rx_e = v;
        wait_clks(BIT);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                              input logic p, input logic stop);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (par_en) send_bit(sel, p);
        send_bit(sel, stop);
    endtask

    int base;
    int ovr_base;

    initial begin
        // Reset state
        wait_clks(5);
        rst = 1'b0;
        wait_clks(3);
        check("rst.rx_valid", 32'(valid_n), 32'd0);
        check("rst.rx_data", 32'(data_n), 32'd0);
        check("rst.frame_err", 32'(ferr_n), 32'd0);
        check("rst.parity_err", 32'(perr_n), 32'd0);
        check("rst.break_det", 32'(brk_n), 32'd0);
        check("rst.overrun", 32'(ovr_n), 32'd0);
        check("rst.busy", 32'(busy_n), 32'd0);

        // 8N1 back-to-back 0x55, 0xA3
        base = qn.size();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT);
        check("b2b.count", 32'(qn.size() - base), 32'd2);
        check_word("b2b.w0", qn[base], 8'h55, 1'b0, 1'b0, 1'b0);
        check_word("b2b.w1", qn[base + 1], 8'hA3, 1'b0, 1'b0, 1'b0);
        check("b2b.busy", 32'(busy_n), 32'd0);

        // Even parity: 0xA3 with wrong parity bit 1, then 0x5A with correct bit 0
        base = qe.size();
        send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1);
        wait_clks(BIT);
        send_frame(1, 8'h5A, 1'b1, 1'b0, 1'b1);
        wait_clks(BIT);
        check("par.count", 32'(qe.size() - base), 32'd2);
        check_word("par.bad", qe[base], 8'hA3, 1'b0, 1'b1, 1'b0);
        check_word("par.good", qe[base + 1], 8'h5A, 1'b0, 1'b0, 1'b0);

        // Stop bit low with data 0x41; busy held until the line returns high
        base = qn.size();
        send_frame(0, 8'h41, 1'b0, 1'b0, 1'b0);
        check("stop0.busy_low_line", 32'(busy_n), 32'd1);
        check("stop0.count", 32'(qn.size() - base), 32'd1);
        check_word("stop0.w", qn[base], 8'h41, 1'b1, 1'b0, 1'b0);
        rx_n = 1'b1;
        wait_clks(20);
        check("stop0.busy_released", 32'(busy_n), 32'd0);
        wait_clks(BIT);

        // Break: line low for two frame times
        base = qn.size();
        rx_n = 1'b0;
        wait_clks(20 * BIT);
        check("brk.count", 32'(qn.size() - base), 32'd1);
        check_word("brk.w", qn[base], 8'h00, 1'b1, 1'b0, 1'b1);
        check("brk.busy", 32'(busy_n), 32'd1);
        rx_n = 1'b1;
        wait_clks(BIT);
        check("brk.count_after", 32'(qn.size() - base), 32'd1);

        // 3-clk glitch, then a valid 0x7E frame
        base = qn.size();
        rx_n = 1'b0;
        wait_clks(3);
        rx_n = 1'b1;
        wait_clks(BIT);
        check("glitch.busy", 32'(busy_n), 32'd0);
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT);
        check("glitch.count", 32'(qn.size() - base), 32'd1);
        check_word("glitch.w", qn[base], 8'h7E, 1'b0, 1'b0, 1'b0);

        // Overrun with consumer stalled
        base = qn.size();
        ovr_base = ovr_cnt;
        ready_n = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT);
        check("ovr.rx_valid", 32'(valid_n), 32'd1);
        check("ovr.rx_data", 32'(data_n), 32'h11);
        check("ovr.pulse_clks", 32'(ovr_cnt - ovr_base), 32'd1);
        check("ovr.no_handshake", 32'(qn.size() - base), 32'd0);

        // Reset in the middle of 0x33 (during data bit 0, which is 1)
        send_bit(0, 1'b0);
        rx_n = 1'b1;
        wait_clks(200);
        rst = 1'b1;
        wait_clks(2);
        check("mrst.rx_valid", 32'(valid_n), 32'd0);
        check("mrst.rx_data", 32'(data_n), 32'd0);
        check("mrst.busy", 32'(busy_n), 32'd0);
        check("mrst.frame_err", 32'(ferr_n), 32'd0);
        check("mrst.overrun", 32'(ovr_n), 32'd0);
        rst = 1'b0;
        ready_n = 1'b1;
        wait_clks(10 * BIT);
        check("mrst.no_word", 32'(qn.size() - base), 32'd0);
        check("mrst.rx_valid_after", 32'(valid_n), 32'd0);
        check("mrst.busy_after", 32'(busy_n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
